// File: rtl/nic_vc_queue.sv
// NIC between a processing element and a ring router. It has one receive FIFO and
// one send FIFO per virtual channel, so a stalled VC cannot block the other one.
module nic_vc_queue #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  input  logic              nicEn,
  input  logic              nicWrEn,
  output logic              net_so,
  input  logic              net_ro,
  output logic [DATA_W-1:0] net_do,
  input  logic              net_polarity,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [DATA_W-1:0] net_di
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  // Packet bit 0 in MSB-first numbering is the top bit of a descending vector.
  localparam int unsigned VC_BIT = DATA_W - 1;

  logic [DATA_W-1:0] in_mem_q [DEPTH];
  logic [PTR_W-1:0]  in_wr_q, in_wr_d, in_rd_q, in_rd_d;
  logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
  logic              in_ovf_q, in_ovf_d;

  logic [DATA_W-1:0] out_mem_q [2][DEPTH];
  logic [PTR_W-1:0]  out_wr_q [2];
  logic [PTR_W-1:0]  out_wr_d [2];
  logic [PTR_W-1:0]  out_rd_q [2];
  logic [PTR_W-1:0]  out_rd_d [2];
  logic [CNT_W-1:0]  out_cnt_q [2];
  logic [CNT_W-1:0]  out_cnt_d [2];
  logic              out_drop_q, out_drop_d;

  logic [DATA_W-1:0] d_out_q, d_out_d;

  logic              in_full, in_empty, in_push, in_pop;
  logic [1:0]        out_full, out_empty, out_push, out_pop;
  logic              rd_en, wr_en, out_wr_req, out_vc, send_vc;

  assign rd_en      = nicEn & ~nicWrEn;
  assign wr_en      = nicEn & nicWrEn;
  assign in_full    = (in_cnt_q == CNT_W'(DEPTH));
  assign in_empty   = (in_cnt_q == '0);
  assign out_full   = {out_cnt_q[1] == CNT_W'(DEPTH), out_cnt_q[0] == CNT_W'(DEPTH)};
  assign out_empty  = {out_cnt_q[1] == '0, out_cnt_q[0] == '0};
  assign out_vc     = d_in[VC_BIT];
  assign out_wr_req = wr_en & (addr == 2'b10);
  assign send_vc    = net_polarity;

  // Network-facing handshakes are combinational; gating with reset drops them immediately.
  assign net_ri  = reset & ~in_full;
  assign net_so  = reset & net_ro & ~out_empty[send_vc];
  assign net_do  = net_so ? out_mem_q[send_vc][out_rd_q[send_vc]] : '0;
  assign d_out   = d_out_q;

  assign in_push = net_si & net_ri;
  assign in_pop  = rd_en & (addr == 2'b00) & ~in_empty;

  always_comb begin
    out_push = 2'b00;
    out_pop  = 2'b00;
    for (int v = 0; v < 2; v++) begin
      out_push[v] = out_wr_req & (out_vc == 1'(v)) & ~out_full[v];
      out_pop[v]  = net_so & (send_vc == 1'(v));
    end
  end

  // Next-state for pointers, counters, sticky flags and the read register.
  always_comb begin
    in_wr_d    = in_wr_q;
    in_rd_d    = in_rd_q;
    in_cnt_d   = in_cnt_q;
    in_ovf_d   = in_ovf_q;
    out_wr_d   = out_wr_q;
    out_rd_d   = out_rd_q;
    out_cnt_d  = out_cnt_q;
    out_drop_d = out_drop_q;
    d_out_d    = '0;

    if (in_push) in_wr_d = in_wr_q + PTR_W'(1);
    if (in_pop)  in_rd_d = in_rd_q + PTR_W'(1);
    in_cnt_d = in_cnt_q + CNT_W'(in_push) - CNT_W'(in_pop);

    for (int v = 0; v < 2; v++) begin
      if (out_push[v]) out_wr_d[v] = out_wr_q[v] + PTR_W'(1);
      if (out_pop[v])  out_rd_d[v] = out_rd_q[v] + PTR_W'(1);
      out_cnt_d[v] = out_cnt_q[v] + CNT_W'(out_push[v]) - CNT_W'(out_pop[v]);
    end

    // Clears come first so a same-edge set wins.
    if (rd_en && addr == 2'b01) in_ovf_d = 1'b0;
    if (net_si && !net_ri)      in_ovf_d = 1'b1;
    if (rd_en && addr == 2'b11) out_drop_d = 1'b0;
    if (out_wr_req && out_full[out_vc]) out_drop_d = 1'b1;

    if (rd_en) begin
      case (addr)
        2'b00: d_out_d = in_empty ? '0 : in_mem_q[in_rd_q];
        2'b01: begin
          d_out_d[0]          = ~in_empty;
          d_out_d[1]          = in_ovf_q;
          d_out_d[2 +: CNT_W] = in_cnt_q;
        end
        2'b11: begin
          d_out_d[0] = out_full[0];
          d_out_d[1] = out_full[1];
          d_out_d[2] = out_drop_q;
        end
        default: d_out_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_wr_q    <= '0;
      in_rd_q    <= '0;
      in_cnt_q   <= '0;
      in_ovf_q   <= 1'b0;
      out_wr_q   <= '{default: '0};
      out_rd_q   <= '{default: '0};
      out_cnt_q  <= '{default: '0};
      out_drop_q <= 1'b0;
      d_out_q    <= '0;
    end else begin
      in_wr_q    <= in_wr_d;
      in_rd_q    <= in_rd_d;
      in_cnt_q   <= in_cnt_d;
      in_ovf_q   <= in_ovf_d;
      out_wr_q   <= out_wr_d;
      out_rd_q   <= out_rd_d;
      out_cnt_q  <= out_cnt_d;
      out_drop_q <= out_drop_d;
      d_out_q    <= d_out_d;
    end
  end

  // Storage needs no reset; validity is tracked by the counters.
  always_ff @(posedge clk) begin
    if (in_push) in_mem_q[in_wr_q] <= net_di;
    for (int v = 0; v < 2; v++) begin
      if (out_push[v]) out_mem_q[v][out_wr_q[v]] <= d_in;
    end
  end

endmodule
